pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
Program-counter and fetch-control stage for the 8-bit processor. Consumes the ALU's branch decision (do_branch) together with the current 5-bit ALU command, and computes the next instruction address. The address comes from sequential increment, a signed relative offset, or a 32-entry branch lookup table. Also owns the run/halt state machine, the done flag and a run-cycle counter.

Parameters:
PCW, 12, program counter width (instruction memory depth 2^PCW)
START_ADDR, 0, PC value loaded on start
LUT_DEPTH, 32, branch lookup table entries (index width 5)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  begin/restart execution (sampled in IDLE and HALT)
alu_cmd  input  5  command of instruction at prog_ctr (same encoding the ALU uses)
do_branch  input  1  ALU branch decision for the current instruction
br_field  input  5  branch immediate: signed offset (BEQ/B) or LUT index (B_LOOKUP)
lut_we  input  1  branch LUT write enable
lut_addr  input  5  branch LUT write index
lut_wdata  input  PCW  branch LUT write data
prog_ctr  output  PCW  current instruction address
fetch_en  output  1  instruction memory read enable, high only in RUN
branch_taken  output  1  registered one-cycle pulse after any taken branch
done  output  1  high while in HALT
cycle_cnt  output  16  RUN cycles since last start, saturating

Behaviour:
- Reset is asynchronous and active-high. It forces: state=IDLE, prog_ctr=0, fetch_en=0, branch_taken=0, done=0, cycle_cnt=0, all LUT entries=0.
- Command codes used: BEQ=5'b00011, B=5'b00010, B_LOOKUP=5'b00001, DONE=5'b10010. All other codes are non-control.
- FSM states: IDLE, RUN, HALT.
- IDLE: fetch_en=0. On start=1, go to RUN next edge with prog_ctr=START_ADDR and cycle_cnt=0.
- RUN: fetch_en=1, and cycle_cnt increments each edge, saturating at 16'hFFFF. Next-PC priority, evaluated each edge:
  1. alu_cmd==DONE -> HALT. prog_ctr holds. DONE wins even if do_branch=1.
  2. do_branch=1 and alu_cmd==B_LOOKUP -> prog_ctr=lut[br_field].
  3. do_branch=1 and alu_cmd in {BEQ,B} -> prog_ctr = prog_ctr + sign_extend(br_field). Range is -16..+15, computed modulo 2^PCW (wraps both directions).
  4. Otherwise -> prog_ctr+1, modulo 2^PCW (2^PCW-1 wraps to 0). do_branch=1 with a non-branch command is ignored.
- start is ignored while in RUN.
- branch_taken=1 for exactly the cycle after an edge that took case 2 or 3; 0 otherwise.
- HALT: done=1, fetch_en=0, prog_ctr and cycle_cnt hold. On start=1, go to RUN with prog_ctr=START_ADDR and cycle_cnt=0; done drops on that same edge.
- Latency: next-PC selection is combinational from inputs, and prog_ctr is registered. A branch decided at cycle N fetches the target at N+1 with no bubble.
- LUT is a synchronous write, combinational read, writable in any state.
  - A same-cycle write and lookup of the same index reads the OLD value; the new value is visible from the next cycle.
  - lut_addr out of range cannot occur (5-bit index, 32 entries).
- Reset mid-RUN: immediate return to IDLE with reset values. The LUT is also cleared.
- Inputs alu_cmd, do_branch and br_field are don't-care outside RUN.

Test Plan:
- Reset then start pulse, alu_cmd=5'b01000 (ADD) for 4 cycles -> prog_ctr 0,1,2,3,4; fetch_en=1; cycle_cnt=4; done=0.
- At prog_ctr=10: BEQ, do_branch=1, br_field=5'b11101 (-3) -> prog_ctr=7 next cycle, branch_taken pulses once. Same with do_branch=0 -> prog_ctr=11, no pulse.
- Write lut[4]=12'h3A0, then B_LOOKUP with br_field=4 and do_branch=1 -> prog_ctr=12'h3A0. Same-cycle rewrite of lut[4]=12'h100 during that lookup -> still 12'h3A0.
- At prog_ctr=12'hFFF: ADD -> prog_ctr=0. At prog_ctr=2: B, br_field=5'b10000 (-16) -> prog_ctr=12'hFF2.
- DONE with do_branch=1 at prog_ctr=20 -> HALT, done=1, prog_ctr stays 20, fetch_en=0, cycle_cnt frozen. Then start -> prog_ctr=0, done=0, cycle_cnt=0.
- Assert reset asynchronously mid-RUN at prog_ctr=9 -> all outputs 0 immediately (before next clk edge), state IDLE, lut[4] reads 0 afterwards.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch control for the 8-bit processor.
// Selects the next instruction address from increment, a signed relative
// offset or a 32-entry branch lookup table. Owns the IDLE/RUN/HALT
// sequencing, the done flag and a saturating run-cycle counter.
module pc_fetch_ctrl #(
   parameter int             PCW        = 12,
   parameter logic [PCW-1:0] START_ADDR = '0,
   parameter int             LUT_DEPTH  = 32
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [4:0]     alu_cmd,
   input  logic           do_branch,
   input  logic [4:0]     br_field,
   input  logic           lut_we,
   input  logic [4:0]     lut_addr,
   input  logic [PCW-1:0] lut_wdata,
   output logic [PCW-1:0] prog_ctr,
   output logic           fetch_en,
   output logic           branch_taken,
   output logic           done,
   output logic [15:0]    cycle_cnt
);

   localparam logic [4:0] CMD_B_LOOKUP = 5'b00001;
   localparam logic [4:0] CMD_B        = 5'b00010;
   localparam logic [4:0] CMD_BEQ      = 5'b00011;
   localparam logic [4:0] CMD_DONE     = 5'b10010;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_HALT
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic [PCW-1:0] pc_nxt;
   logic [15:0]    cnt_nxt;
   logic           taken_nxt;
   logic [PCW-1:0] lut [LUT_DEPTH];

   // Sign-extend the 5-bit branch immediate to PC width; the add then
   // wraps naturally modulo 2^PCW in both directions.
   function automatic logic signed [PCW-1:0] br_offset(input logic [4:0] f);
      return {{(PCW-5){f[4]}}, f};
   endfunction

   // Increment that sticks at the maximum count instead of wrapping.
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Outputs decoded straight from state so reset clears them immediately.
   assign fetch_en = (state == S_RUN);
   assign done     = (state == S_HALT);

   // State, PC, counter and branch pulse registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         prog_ctr     <= '0;
         cycle_cnt    <= '0;
         branch_taken <= 1'b0;
      end else begin
         state        <= state_nxt;
         prog_ctr     <= pc_nxt;
         cycle_cnt    <= cnt_nxt;
         branch_taken <= taken_nxt;
      end
   end

   // Branch table: synchronous write, cleared by reset; reads are
   // combinational so a same-cycle write is seen only on the next cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < LUT_DEPTH; i++) begin
            lut[i] <= '0;
         end
      end else if (lut_we) begin
         lut[lut_addr] <= lut_wdata;
      end
   end

   // Next-state and next-PC selection; DONE has priority over any branch.
   always_comb begin
      state_nxt = state;
      pc_nxt    = prog_ctr;
      cnt_nxt   = cycle_cnt;
      taken_nxt = 1'b0;
      unique case (state)
         S_IDLE, S_HALT: begin
            if (start) begin
               state_nxt = S_RUN;
               pc_nxt    = START_ADDR;
               cnt_nxt   = '0;
            end
         end
         S_RUN: begin
            cnt_nxt = sat_inc(cycle_cnt);
            if (alu_cmd == CMD_DONE) begin
               state_nxt = S_HALT;
            end else if (do_branch && alu_cmd == CMD_B_LOOKUP) begin
               pc_nxt    = lut[br_field];
               taken_nxt = 1'b1;
            end else if (do_branch && (alu_cmd == CMD_BEQ || alu_cmd == CMD_B)) begin
               pc_nxt    = prog_ctr + $unsigned(br_offset(br_field));
               taken_nxt = 1'b1;
            end else begin
               pc_nxt = prog_ctr + 1'b1;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios followed by
// randomized traffic against a behavioural reference model.
module tb_pc_fetch_ctrl;

   localparam logic [4:0] ADD    = 5'b01000;
   localparam logic [4:0] LOOKUP = 5'b00001;
   localparam logic [4:0] BR     = 5'b00010;
   localparam logic [4:0] BEQ    = 5'b00011;
   localparam logic [4:0] DONE   = 5'b10010;

   logic        clk;
   logic        reset;
   logic        start;
   logic [4:0]  alu_cmd;
   logic        do_branch;
   logic [4:0]  br_field;
   logic        lut_we;
   logic [4:0]  lut_addr;
   logic [11:0] lut_wdata;
   logic [11:0] prog_ctr;
   logic        fetch_en;
   logic        branch_taken;
   logic        done;
   logic [15:0] cycle_cnt;

   int checks;
   int failures;
   bit checking_on;

   // reference model state
   int m_pc;
   int m_cnt;
   bit m_run;
   bit m_halt;
   bit m_bt;
   int m_lut [32];

   pc_fetch_ctrl #(.PCW(12), .START_ADDR(12'h000), .LUT_DEPTH(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .alu_cmd      (alu_cmd),
      .do_branch    (do_branch),
      .br_field     (br_field),
      .lut_we       (lut_we),
      .lut_addr     (lut_addr),
      .lut_wdata    (lut_wdata),
      .prog_ctr     (prog_ctr),
      .fetch_en     (fetch_en),
      .branch_taken (branch_taken),
      .done         (done),
      .cycle_cnt    (cycle_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      m_pc   = 0;
      m_cnt  = 0;
      m_run  = 0;
      m_halt = 0;
      m_bt   = 0;
      for (int i = 0; i < 32; i++) m_lut[i] = 0;
   endfunction

   // Advance the model by one clock edge using the inputs currently applied.
   function automatic void model_edge();
      int nxt;
      int off;
      bit bt;
      if (reset) begin
         model_reset();
         return;
      end
      nxt = m_pc;
      bt  = 0;
      if (m_run) begin
         m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
         if (alu_cmd == DONE) begin
            m_run  = 0;
            m_halt = 1;
         end else if (do_branch && alu_cmd == LOOKUP) begin
            nxt = m_lut[br_field];
            bt  = 1;
         end else if (do_branch && (alu_cmd == BEQ || alu_cmd == BR)) begin
            off = br_field;
            if (off >= 16) off = off - 32;
            nxt = (m_pc + off + 4096) % 4096;
            bt  = 1;
         end else begin
            nxt = (m_pc + 1) % 4096;
         end
      end else if (start) begin
         m_run  = 1;
         m_halt = 0;
         m_cnt  = 0;
         nxt    = 0;
      end
      if (lut_we) m_lut[lut_addr] = lut_wdata;
      m_pc = nxt;
      m_bt = bt;
   endfunction

   task automatic compare_all(input string tag);
      check_val({tag, ".pc"},   prog_ctr,     m_pc);
      check_val({tag, ".fe"},   fetch_en,     m_run);
      check_val({tag, ".done"}, done,         m_halt);
      check_val({tag, ".bt"},   branch_taken, m_bt);
      check_val({tag, ".cnt"},  cycle_cnt,    m_cnt);
   endtask

   // One clock cycle: apply inputs at the falling edge, check after rising edge.
   task automatic step(input logic st, input logic [4:0] cmd, input logic db,
                       input logic [4:0] bf, input logic we, input logic [4:0] wa,
                       input logic [11:0] wd, input string tag);
      start     = st;
      alu_cmd   = cmd;
      do_branch = db;
      br_field  = bf;
      lut_we    = we;
      lut_addr  = wa;
      lut_wdata = wd;
      @(posedge clk);
      model_edge();
      #1;
      if (checking_on) compare_all(tag);
      @(negedge clk);
   endtask

   task automatic jump_to(input logic [11:0] a);
      step(1'b0, ADD, 1'b0, 5'd0, 1'b1, 5'd31, a, "jump_wr");
      step(1'b0, LOOKUP, 1'b1, 5'd31, 1'b0, 5'd0, 12'h0, "jump_lk");
   endtask

   initial begin
      int r;
      int held_cnt;
      logic [4:0] cmd;
      checks      = 0;
      failures    = 0;
      checking_on = 1;
      model_reset();
      reset     = 1'b1;
      start     = 1'b0;
      alu_cmd   = 5'd0;
      do_branch = 1'b0;
      br_field  = 5'd0;
      lut_we    = 1'b0;
      lut_addr  = 5'd0;
      lut_wdata = 12'h0;
      #12;
      compare_all("reset");
      @(negedge clk);
      reset = 1'b0;

      // start and sequential increment
      step(1'b1, ADD, 1'b0, 5'd0, 1'b0, 5'd0, 12'h0, "start");
      check_val("start_pc", prog_ctr, 12'h000);
      for (int i = 0; i < 4; i++) step(1'b0, ADD, 1'b0, 5'd0, 1'b0, 5'd0, 12'h0, "add");
      check_val("add4_pc", prog_ctr, 12'h004);
      check_val("add4_cnt", cycle_cnt, 16'd4);
      check_val("add4_fe", fetch_en, 1'b1);

      // relative branch taken and not taken
      jump_to(12'd10);
      step(1'b0, BEQ, 1'b1, 5'b11101, 1'b0, 5'd0, 12'h0, "beq_t");
      check_val("beq_t_pc", prog_ctr, 12'd7);
      check_val("beq_t_bt", branch_taken, 1'b1);
      step(1'b0, ADD, 1'b0, 5'd0, 1'b0, 5'd0, 12'h0, "after_beq");
      check_val("bt_one_shot", branch_taken, 1'b0);
      jump_to(12'd10);
      step(1'b0, BEQ, 1'b0, 5'b11101, 1'b0, 5'd0, 12'h0, "beq_n");
      check_val("beq_n_pc", prog_ctr, 12'd11);
      check_val("beq_n_bt", branch_taken, 1'b0);

      // lookup branch, same-cycle rewrite reads the old entry
      step(1'b0, ADD, 1'b0, 5'd0, 1'b1, 5'd4, 12'h3A0, "lut_wr");
      step(1'b0, LOOKUP, 1'b1, 5'd4, 1'b1, 5'd4, 12'h100, "lut_rw");
      check_val("lut_old", prog_ctr, 12'h3A0);
      step(1'b0, LOOKUP, 1'b1, 5'd4, 1'b0, 5'd0, 12'h0, "lut_new");
      check_val("lut_new_pc", prog_ctr, 12'h100);

      // wrap both directions
      jump_to(12'hFFF);
      step(1'b0, ADD, 1'b0, 5'd0, 1'b0, 5'd0, 12'h0, "wrap_up");
      check_val("wrap_up_pc", prog_ctr, 12'h000);
      step(1'b0, ADD, 1'b1, 5'd3, 1'b0, 5'd0, 12'h0, "nonbr_db");
      step(1'b0, ADD, 1'b0, 5'd0, 1'b0, 5'd0, 12'h0, "add");
      check_val("nonbr_db_pc", prog_ctr, 12'h002);
      step(1'b0, BR, 1'b1, 5'b10000, 1'b0, 5'd0, 12'h0, "wrap_dn");
      check_val("wrap_dn_pc", prog_ctr, 12'hFF2);

      // DONE beats branch, HALT holds, restart
      jump_to(12'd20);
      step(1'b0, DONE, 1'b1, 5'd4, 1'b0, 5'd0, 12'h0, "done");
      check_val("done_pc", prog_ctr, 12'd20);
      check_val("done_flag", done, 1'b1);
      check_val("done_fe", fetch_en, 1'b0);
      held_cnt = m_cnt;
      step(1'b0, BEQ, 1'b1, 5'd3, 1'b0, 5'd0, 12'h0, "halt1");
      step(1'b0, ADD, 1'b0, 5'd0, 1'b0, 5'd0, 12'h0, "halt2");
      check_val("halt_cnt_hold", cycle_cnt, held_cnt);
      check_val("halt_pc_hold", prog_ctr, 12'd20);
      step(1'b1, ADD, 1'b0, 5'd0, 1'b0, 5'd0, 12'h0, "restart");
      check_val("restart_pc", prog_ctr, 12'h000);
      check_val("restart_done", done, 1'b0);
      check_val("restart_cnt", cycle_cnt, 16'd0);

      // asynchronous reset mid-run clears everything including the LUT
      jump_to(12'd9);
      check_val("pre_rst_pc", prog_ctr, 12'd9);
      #2;
      reset = 1'b1;
      #1;
      check_val("arst_pc", prog_ctr, 12'h000);
      check_val("arst_fe", fetch_en, 1'b0);
      check_val("arst_bt", branch_taken, 1'b0);
      check_val("arst_done", done, 1'b0);
      check_val("arst_cnt", cycle_cnt, 16'd0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      step(1'b0, ADD, 1'b0, 5'd0, 1'b0, 5'd0, 12'h0, "idle_hold");
      check_val("idle_fe", fetch_en, 1'b0);
      step(1'b1, ADD, 1'b0, 5'd0, 1'b0, 5'd0, 12'h0, "start2");
      step(1'b0, LOOKUP, 1'b1, 5'd4, 1'b0, 5'd0, 12'h0, "lut_cleared");
      check_val("lut_cleared_pc", prog_ctr, 12'h000);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         r = $urandom_range(0, 15);
         case (r)
            0, 1, 2: cmd = BEQ;
            3, 4:    cmd = BR;
            5, 6, 7: cmd = LOOKUP;
            8:       cmd = ($urandom_range(0, 3) == 0) ? DONE : ADD;
            default: cmd = 5'($urandom_range(0, 31));
         endcase
         reset = ($urandom_range(0, 299) == 0);
         step(($urandom_range(0, 5) == 0), cmd, 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 31)), ($urandom_range(0, 3) == 0),
              5'($urandom_range(0, 31)), 12'($urandom_range(0, 4095)), "rand");
      end
      reset = 1'b0;

      // counter saturation
      step(1'b0, DONE, 1'b0, 5'd0, 1'b0, 5'd0, 12'h0, "pre_sat");
      step(1'b1, ADD, 1'b0, 5'd0, 1'b0, 5'd0, 12'h0, "sat_start");
      checking_on = 0;
      repeat (65540) step(1'b0, ADD, 1'b0, 5'd0, 1'b0, 5'd0, 12'h0, "sat");
      checking_on = 1;
      check_val("cnt_sat", cycle_cnt, 16'hFFFF);
      step(1'b0, ADD, 1'b0, 5'd0, 1'b0, 5'd0, 12'h0, "sat_hold");
      check_val("cnt_sat_hold", cycle_cnt, 16'hFFFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
